// File: rtl/arith_seq_pkg.sv
// Shared types, opcode encodings and carry/operand selection helpers for the
// bit-serial arithmetic sequencer.
package arith_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_INC  = 3'b010;
    localparam logic [2:0] OP_SUB2 = 3'b011;
    localparam logic [2:0] OP_PASS = 3'b100;
    localparam logic [2:0] OP_DEC  = 3'b101;
    localparam logic [2:0] OP_ADC  = 3'b110;
    localparam logic [2:0] OP_ADC2 = 3'b111;

    function automatic logic init_carry(input logic [2:0] opsel, input logic cin);
        logic c;
        case (opsel)
            OP_ADD:  c = 1'b0;
            OP_SUB:  c = 1'b1;
            OP_INC:  c = 1'b1;
            OP_SUB2: c = 1'b1;
            OP_PASS: c = 1'b0;
            OP_DEC:  c = 1'b0;
            default: c = cin;
        endcase
        return c;
    endfunction

    // Per-bit B operand seen by the slice; DEC adds all-ones, INC/PASS add zero.
    function automatic logic slice_b(input logic [2:0] opsel, input logic b_bit);
        logic r;
        case (opsel)
            OP_ADD:  r = b_bit;
            OP_SUB:  r = ~b_bit;
            OP_INC:  r = 1'b0;
            OP_SUB2: r = ~b_bit;
            OP_PASS: r = 1'b0;
            OP_DEC:  r = 1'b1;
            default: r = b_bit;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/arith_seq_ctrl_arth_unit.sv
// One-bit arithmetic slice: full adder stepped once per clock by the sequencer.
module arth_unit (
    input  logic op1_i,
    input  logic op2_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = op1_i ^ op2_i ^ cin_i;
    assign cout_o = (op1_i & op2_i) | (cin_i & (op1_i ^ op2_i));

endmodule

// File: rtl/arith_seq_ctrl.sv
// Bit-serial sequencer driving one arth_unit slice LSB-first over WIDTH cycles.
// Optional `zero` result flag is enabled by defining ARITH_SEQ_ZERO_FLAG_EN.
module arith_seq_ctrl
    import arith_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opsel,
    input  logic             cin,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
`ifdef ARITH_SEQ_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, res_sh_q;
    logic [2:0]       op_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q, cout_q, ovf_q;
    logic [WIDTH-1:0] result_q;

    logic             slice_b_bit, slice_sum, slice_co;
    logic [WIDTH-1:0] res_sh_d;

    assign slice_b_bit = slice_b(op_q, b_sh_q[0]);
    assign res_sh_d    = {slice_sum, res_sh_q[WIDTH-1:1]};

    arth_unit u_slice (
        .op1_i  (a_sh_q[0]),
        .op2_i  (slice_b_bit),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_co)
    );

`ifdef ARITH_SEQ_ZERO_FLAG_EN
    logic zacc_q, zero_q;

    // Zero is the inverse OR of every result bit seen during RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zacc_q <= 1'b0;
            zero_q <= 1'b0;
        end else if (state_q != RUN) begin
            if (start) zacc_q <= 1'b0;
        end else if (!abort) begin
            zacc_q <= zacc_q | slice_sum;
            if (cnt_q == LAST) zero_q <= ~(zacc_q | slice_sum);
        end
    end

    assign zero = zero_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        a_sh_q   <= a_sh_q >> 1;
                        b_sh_q   <= b_sh_q >> 1;
                        res_sh_q <= res_sh_d;
                        carry_q  <= slice_co;
                        if (cnt_q == LAST) begin
                            // carry_q is the carry into the MSB on this final step.
                            state_q  <= DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            result_q <= res_sh_d;
                            cout_q   <= slice_co;
                            ovf_q    <= carry_q ^ slice_co;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        op_q    <= opsel;
                        carry_q <= init_carry(opsel, cin);
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_arith_seq_ctrl.sv
// Scoreboard bench for arith_seq_ctrl: word-level reference model, directed
// cases followed by randomized back-to-back operations.
module tb_arith_seq_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         cin = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   opsel = '0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] result;
`ifdef ARITH_SEQ_ZERO_FLAG_EN
    logic         zero;
`endif

    arith_seq_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .opsel  (opsel),
        .cin    (cin),
        .abort  (abort),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
`ifdef ARITH_SEQ_ZERO_FLAG_EN
        ,
        .zero   (zero)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        int           dcyc;
    } exp_t;

    exp_t         sbq[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [W-1:0] last_res = '0;
    logic         last_co = 1'b0;
    logic         last_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Word-level model: result = a + B + c0 with B and c0 chosen by opcode.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic [2:0] mop, input logic mc);
        exp_t         e;
        logic [W-1:0] bw;
        logic         c0;
        logic [W:0]   s;
        case (mop)
            3'd0:       begin bw = mb;        c0 = 1'b0; end
            3'd1, 3'd3: begin bw = ~mb;       c0 = 1'b1; end
            3'd2:       begin bw = '0;        c0 = 1'b1; end
            3'd4:       begin bw = '0;        c0 = 1'b0; end
            3'd5:       begin bw = '1;        c0 = 1'b0; end
            default:    begin bw = mb;        c0 = mc;   end
        endcase
        s      = {1'b0, ma} + {1'b0, bw} + {{W{1'b0}}, c0};
        e.res  = s[W-1:0];
        e.co   = s[W];
        e.ov   = (ma[W-1] == bw[W-1]) && (s[W-1] != ma[W-1]);
        e.dcyc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("result", result, e.res);
                    chk("cout", cout, e.co);
                    chk("ovf", ovf, e.ov);
                    chk("done_latency", cyc, e.dcyc);
`ifdef ARITH_SEQ_ZERO_FLAG_EN
                    chk("zero", zero, (e.res == '0));
`endif
                    last_res = e.res;
                    last_co  = e.co;
                    last_ov  = e.ov;
                end
            end else if (busy) begin
                chk("hold_outputs", {result, cout, ovf}, {last_res, last_co, last_ov});
            end
        end
    end

    // Called just after a clock edge; the start is accepted at the following edge.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                            input logic [2:0] top, input logic tc);
        exp_t e;
        a     = ta;
        b     = tb;
        opsel = top;
        cin   = tc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        e      = model(ta, tb, top, tc);
        e.dcyc = cyc + W;
        sbq.push_back(e);
        chk("busy_after_start", busy, 1'b1);
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int t = 0; t < W + 4; t++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_timeout actual=0 expected=1 (cycle %0d)", cyc);
        end
        chk("busy_at_done", busy, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_result", result, 8'h00);
        chk("rst_cout", cout, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        #9 rst = 1'b0;
        @(posedge clk);
        #1;

        start_op(8'h35, 8'h4A, 3'b000, 1'b0); wait_done();
        chk("add_35_4a", {result, cout, ovf}, {8'h7F, 1'b0, 1'b0});
        start_op(8'h10, 8'h20, 3'b001, 1'b0); wait_done();
        chk("sub_10_20", {result, cout, ovf}, {8'hF0, 1'b0, 1'b0});
        start_op(8'h20, 8'h10, 3'b001, 1'b0); wait_done();
        chk("sub_20_10", {result, cout}, {8'h10, 1'b1});
        start_op(8'h7F, 8'h01, 3'b000, 1'b0); wait_done();
        chk("add_ovf", {result, ovf}, {8'h80, 1'b1});
        start_op(8'hFF, 8'h00, 3'b010, 1'b0); wait_done();
        chk("inc_ff", {result, cout}, {8'h00, 1'b1});
        start_op(8'h00, 8'h5A, 3'b101, 1'b0); wait_done();
        chk("dec_00", {result, cout}, {8'hFF, 1'b0});

        // start held high through RUN must not queue another op
        start_op(8'h12, 8'h34, 3'b000, 1'b0);
        start = 1'b1;
        repeat (W - 3) @(posedge clk);
        #1 start = 1'b0;
        wait_done();

        // back-to-back: each start is issued in the DONE cycle
        start_op(8'hC3, 8'h3C, 3'b011, 1'b0); wait_done();
        start_op(8'h9A, 8'h00, 3'b100, 1'b0); wait_done();
        chk("pass_9a", result, 8'h9A);

        // start and abort together in DONE/IDLE: start wins
        abort = 1'b1;
        start_op(8'h01, 8'h01, 3'b110, 1'b1);
        abort = 1'b0;
        wait_done();
        chk("adc_01_01_c1", result, 8'h03);
        repeat (2) @(posedge clk);
        #1;

        // abort during the third RUN cycle
        start_op(8'h55, 8'h22, 3'b000, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        void'(sbq.pop_back());
        chk("abort_busy", busy, 1'b0);
        repeat (W + 3) @(posedge clk);
        #1;
        chk("abort_result_kept", result, 8'h03);

        for (int i = 0; i < 150; i++) begin
            start_op(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)), 1'($urandom));
            wait_done();
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

`ifdef ARITH_SEQ_ZERO_FLAG_EN
        start_op(8'h80, 8'h80, 3'b000, 1'b0); wait_done();
        chk("zero_80_80", {zero, cout, ovf}, {1'b1, 1'b1, 1'b1});
`endif

        // asynchronous reset mid-RUN, between clock edges
        start_op(8'hA5, 8'h5A, 3'b000, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrun_rst_busy", busy, 1'b0);
        chk("midrun_rst_done", done, 1'b0);
        chk("midrun_rst_result", result, 8'h00);
        chk("midrun_rst_cout", cout, 1'b0);
        chk("midrun_rst_ovf", ovf, 1'b0);
        sbq.delete();
        last_res = '0;
        last_co  = 1'b0;
        last_ov  = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        start_op(8'h0F, 8'h01, 3'b000, 1'b0); wait_done();
        chk("after_rst_add", result, 8'h10);
        repeat (3) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
